ptw_sv39: RTL

// Sv39 hardware page-table walker directly downstream of shared_tlb. When the shared TLB reports an access

---
 rtl/mmu_pkg.sv | 45 ++++
 rtl/ptw_pte_check.sv | 33 +++
 rtl/ptw_sv39.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - Sv39 MMU types and constants shared by the page-table walker
package mmu_pkg;

    localparam int VLEN       = 39;
    localparam int XLEN       = 64;
    localparam int PLEN       = 56;
    localparam int PpnLen     = 44;
    localparam int PtLevels   = 3;
    localparam int VpnLen     = 27;
    localparam int ASID_WIDTH = 16;

    localparam logic [3:0] ModeSv39 = 4'h8;

    typedef struct packed {
        logic [9:0]        reserved;
        logic [PpnLen-1:0] ppn;
        logic [1:0]        rsw;
        logic              d;
        logic              a;
        logic              g;
        logic              u;
        logic              x;
        logic              w;
        logic              r;
        logic              v;
    } pte_cva6_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            is_page;
        logic [VpnLen-1:0]     vpn;
        logic [ASID_WIDTH-1:0] asid;
        pte_cva6_t             content;
    } tlb_update_cva6_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        PROPAGATE_ERROR,
        PROPAGATE_ACCESS_ERROR,
        LATENCY
    } ptw_state_e;

endpackage

// File: rtl/ptw_pte_check.sv
// rtl/ptw_pte_check.sv - combinational Sv39 PTE classification into leaf / page-fault
module ptw_pte_check
    import mmu_pkg::*;
(
    input  pte_cva6_t  pte,
    input  logic [1:0] level,
    input  logic       is_store,
    input  logic       is_instr,
    output logic       leaf,
    output logic       fault
);

    logic invalid;
    logic is_leaf;
    logic misaligned;
    logic perm_fault;
    logic unused_pte;

    // level 0 maps 1 GiB, level 1 maps 2 MiB; lower PPN bits of a superpage must be zero
    assign invalid    = ~pte.v | (~pte.r & pte.w);
    assign is_leaf    = pte.r | pte.x;
    assign misaligned = ((level == 2'd0) && (pte.ppn[17:0] != '0))
                      | ((level == 2'd1) && (pte.ppn[8:0] != '0));
    assign perm_fault = ~pte.a | (~is_instr & is_store & (~pte.w | ~pte.d));

    assign leaf  = ~invalid & is_leaf;
    assign fault = invalid
                 | (is_leaf & (perm_fault | misaligned))
                 | (~is_leaf & (level == 2'd2));

    assign unused_pte = ^{pte.reserved, pte.rsw, pte.g, pte.u, pte.ppn[43:18]};

endmodule

// File: rtl/ptw_sv39.sv
// rtl/ptw_sv39.sv - Sv39 page-table walker behind the shared TLB, one outstanding PTE read
module ptw_sv39
    import mmu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  enable_translation_i,
    input  logic [PpnLen-1:0]     satp_ppn_i,
    input  logic [ASID_WIDTH-1:0] itlb_asid_i,
    input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
    input  logic                  lsu_is_store_i,
    input  logic                  shared_tlb_access_i,
    input  logic                  shared_tlb_hit_i,
    input  logic [VLEN-1:0]       shared_tlb_vaddr_i,
    input  logic                  itlb_req_i,
    output logic                  shared_tlb_miss_o,
    output logic                  mem_req_o,
    output logic [PLEN-1:0]       mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  mem_rerr_i,
    output tlb_update_cva6_t      shared_tlb_update_o,
    output logic                  ptw_active_o,
    output logic                  walking_instr_o,
    output logic                  ptw_error_o,
    output logic                  ptw_access_exception_o,
    output logic [VLEN-1:0]       bad_vaddr_o
);

    ptw_state_e            state_q, state_d;
    logic [1:0]            level_q, level_d;
    logic [PLEN-1:0]       addr_q, addr_d;
    logic                  kill_q, kill_d;
    logic [VLEN-1:0]       vaddr_q;
    logic                  is_instr_q;
    logic                  is_store_q;
    logic [ASID_WIDTH-1:0] asid_q;
    tlb_update_cva6_t      update_q, update_d;

    logic                  start;
    pte_cva6_t             pte;
    logic                  pte_leaf;
    logic                  pte_fault;
    logic [8:0]            next_idx;

    assign pte   = pte_cva6_t'(mem_rdata_i);
    assign start = (state_q == IDLE) & shared_tlb_access_i & ~shared_tlb_hit_i
                 & enable_translation_i & ~flush_i;

    ptw_pte_check u_pte_check (
        .pte      (pte),
        .level    (level_q),
        .is_store (is_store_q),
        .is_instr (is_instr_q),
        .leaf     (pte_leaf),
        .fault    (pte_fault)
    );

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        addr_d   = addr_q;
        kill_d   = kill_q;
        update_d = '0;
        next_idx = (level_q == 2'd0) ? vaddr_q[29:21] : vaddr_q[20:12];

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (start) begin
                    level_d = 2'd0;
                    addr_d  = {satp_ppn_i, shared_tlb_vaddr_i[38:30], 3'b000};
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (flush_i) kill_d = 1'b1;
                if (mem_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (flush_i) kill_d = 1'b1;
                if (mem_rvalid_i) begin
                    // a killed walk drains its read silently and never reports
                    if (kill_q | flush_i) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else if (mem_rerr_i) begin
                        state_d = PROPAGATE_ACCESS_ERROR;
                    end else if (pte_fault) begin
                        state_d = PROPAGATE_ERROR;
                    end else if (pte_leaf) begin
                        update_d.valid   = 1'b1;
                        update_d.is_page = {level_q == 2'd1, level_q == 2'd0};
                        update_d.vpn     = vaddr_q[38:12];
                        update_d.asid    = asid_q;
                        update_d.content = pte;
                        state_d          = LATENCY;
                    end else begin
                        level_d = level_q + 2'd1;
                        addr_d  = {pte.ppn, next_idx, 3'b000};
                        state_d = WAIT_GNT;
                    end
                end
            end
            PROPAGATE_ERROR,
            PROPAGATE_ACCESS_ERROR,
            LATENCY: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            level_q    <= 2'd0;
            addr_q     <= '0;
            kill_q     <= 1'b0;
            vaddr_q    <= '0;
            is_instr_q <= 1'b0;
            is_store_q <= 1'b0;
            asid_q     <= '0;
            update_q   <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            kill_q   <= kill_d;
            update_q <= update_d;
            if (start) begin
                vaddr_q    <= shared_tlb_vaddr_i;
                is_instr_q <= itlb_req_i;
                is_store_q <= lsu_is_store_i;
                asid_q     <= itlb_req_i ? itlb_asid_i : dtlb_asid_i;
            end
        end
    end

    assign shared_tlb_miss_o      = start;
    assign mem_req_o              = (state_q == WAIT_GNT);
    assign mem_addr_o             = addr_q;
    assign shared_tlb_update_o    = update_q;
    assign ptw_active_o           = (state_q != IDLE);
    assign walking_instr_o        = is_instr_q & ptw_active_o;
    assign ptw_error_o            = (state_q == PROPAGATE_ERROR);
    assign ptw_access_exception_o = (state_q == PROPAGATE_ACCESS_ERROR);
    assign bad_vaddr_o            = (ptw_error_o | ptw_access_exception_o) ? vaddr_q : '0;

endmodule
